lsp_stability_fsm: RTL and testbench

- Sequential FSM implementing the G.729 `Lsp_stability` routine on a 10-entry quantized-LSF buffer held in shared scratch memory.
- Runs in place, directly upstream of the LSF-to-LSP conversion stage in the LSP quantizer; that stage reads the buffer after this block asserts `done`.
- Two passes: a single bubble pass that swaps adjacent out-of-order pairs, then minimum-gap enforcement.
- Low limit L_LIMIT = 40; gap GAP3 = 321; high limit M_LIMIT = 25681.
- All data arithmetic goes through the shared external operator units; only the index counter is internal.

---
 rtl/lsp_stability_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_lsp_stability_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lsp_stability_fsm.sv
// lsp_stability_fsm: in-place LSF stability fix-up on a 10-entry buffer in
// shared scratch memory. It makes one bubble pass that swaps out-of-order
// neighbours. It then clamps buf[0] to at least L_LIMIT and enforces a minimum
// spacing of GAP3 between adjacent entries. Finally it clamps buf[9] to at most
// M_LIMIT. All data arithmetic is done by external operator units.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a run (sampled in IDLE only)
//   bufAddr                    buffer base; element j at {bufAddr[11:4], j}
//   memIn                      scratch read data (one cycle after address)
//   L_subIn / subIn / addIn    results from the shared L_sub / sub / add units
//   L_subOutA/B, subOutA/B,
//   addOutA/B                  operands to the shared operator units
//   memReadAddr, memWriteAddr  scratch addresses
//   memOut, memWriteEn         write data (sign-extended) and write strobe
//   done                       one-cycle completion pulse
// All outputs are combinational and decode from the current state.
module lsp_stability_fsm #(
  parameter logic [15:0] L_LIMIT = 16'd40,
  parameter logic [15:0] GAP3    = 16'd321,
  parameter logic [15:0] M_LIMIT = 16'd25681
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bufAddr,
  input  logic [31:0] memIn,
  input  logic [31:0] L_subIn,
  input  logic [15:0] subIn,
  input  logic [15:0] addIn,
  output logic [31:0] L_subOutA,
  output logic [31:0] L_subOutB,
  output logic [15:0] subOutA,
  output logic [15:0] subOutB,
  output logic [15:0] addOutA,
  output logic [15:0] addOutB,
  output logic [11:0] memReadAddr,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, P1_LOAD, P1_CMP, P1_SWAP, P1_NEXT,
    LIM_CHK, P2_CMP, P2_GAP, MLIM, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  j, j_nxt;
  logic [15:0] a, a_nxt;
  logic [15:0] b, b_nxt;
  logic [31:0] diff, diff_nxt;

  // Upper read-data bits and base low bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{memIn[31:16], bufAddr[3:0]};

  function automatic logic [31:0] sext(input logic [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  function automatic logic [11:0] elem(input logic [11:0] base, input logic [3:0] idx);
    return {base[11:4], idx};
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      j     <= 4'd0;
      a     <= 16'd0;
      b     <= 16'd0;
      diff  <= 32'd0;
    end else begin
      state <= state_nxt;
      j     <= j_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      diff  <= diff_nxt;
    end
  end

  // Next-state, register updates and output decode.
  always_comb begin
    state_nxt    = state;
    j_nxt        = j;
    a_nxt        = a;
    b_nxt        = b;
    diff_nxt     = diff;
    L_subOutA    = 32'd0;
    L_subOutB    = 32'd0;
    subOutA      = 16'd0;
    subOutB      = 16'd0;
    addOutA      = 16'd0;
    addOutB      = 16'd0;
    memReadAddr  = 12'd0;
    memWriteAddr = 12'd0;
    memOut       = 32'd0;
    memWriteEn   = 1'b0;
    done         = 1'b0;

    // Outputs stay at zero while reset is held, whatever the state.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (start) begin
            memReadAddr = elem(bufAddr, 4'd0);
            state_nxt   = P1_LOAD;
          end
        end

        P1_LOAD: begin
          a_nxt       = memIn[15:0];
          j_nxt       = 4'd0;
          memReadAddr = elem(bufAddr, 4'd1);
          state_nxt   = P1_CMP;
        end

        // Carry the larger value forward; on a swap write the smaller one back now.
        P1_CMP: begin
          L_subOutA = sext(memIn[15:0]);
          L_subOutB = sext(a);
          b_nxt     = memIn[15:0];
          if (L_subIn[31]) begin
            memWriteAddr = elem(bufAddr, j);
            memOut       = sext(memIn[15:0]);
            memWriteEn   = 1'b1;
            state_nxt    = P1_SWAP;
          end else begin
            a_nxt     = memIn[15:0];
            state_nxt = P1_NEXT;
          end
        end

        P1_SWAP: begin
          memWriteAddr = elem(bufAddr, 4'(j + 4'd1));
          memOut       = sext(a);
          memWriteEn   = 1'b1;
          state_nxt    = P1_NEXT;
        end

        P1_NEXT: begin
          if (j == 4'd8) begin
            memReadAddr = elem(bufAddr, 4'd0);
            state_nxt   = LIM_CHK;
          end else begin
            j_nxt       = 4'(j + 4'd1);
            memReadAddr = elem(bufAddr, 4'(j + 4'd2));
            state_nxt   = P1_CMP;
          end
        end

        LIM_CHK: begin
          subOutA = memIn[15:0];
          subOutB = L_LIMIT;
          if (subIn[15]) begin
            memWriteAddr = elem(bufAddr, 4'd0);
            memOut       = sext(L_LIMIT);
            memWriteEn   = 1'b1;
            a_nxt        = L_LIMIT;
          end else begin
            a_nxt = memIn[15:0];
          end
          j_nxt       = 4'd0;
          memReadAddr = elem(bufAddr, 4'd1);
          state_nxt   = P2_CMP;
        end

        P2_CMP: begin
          L_subOutA = sext(memIn[15:0]);
          L_subOutB = sext(a);
          diff_nxt  = L_subIn;
          b_nxt     = memIn[15:0];
          state_nxt = P2_GAP;
        end

        // Gap test and saturating corrected value are computed side by side.
        P2_GAP: begin
          L_subOutA = diff;
          L_subOutB = sext(GAP3);
          addOutA   = a;
          addOutB   = GAP3;
          if (L_subIn[31]) begin
            memWriteAddr = elem(bufAddr, 4'(j + 4'd1));
            memOut       = sext(addIn);
            memWriteEn   = 1'b1;
            a_nxt        = addIn;
          end else begin
            a_nxt = b;
          end
          if (j == 4'd8) begin
            state_nxt = MLIM;
          end else begin
            j_nxt       = 4'(j + 4'd1);
            memReadAddr = elem(bufAddr, 4'(j + 4'd2));
            state_nxt   = P2_CMP;
          end
        end

        // Only strictly greater than M_LIMIT is rewritten.
        MLIM: begin
          subOutA = a;
          subOutB = M_LIMIT;
          if (!subIn[15] && (subIn != 16'd0)) begin
            memWriteAddr = elem(bufAddr, 4'd9);
            memOut       = sext(M_LIMIT);
            memWriteEn   = 1'b1;
          end
          state_nxt = DONE;
        end

        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_stability_fsm.sv
// Bench for lsp_stability_fsm: scratch memory and saturating operator units
// around the DUT, a behavioural Lsp_stability model feeding a queue of
// expected results, compared when done pulses.
module tb_lsp_stability_fsm;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] bufAddr;
  logic [31:0] memIn = 32'd0;
  logic [31:0] L_subIn;
  logic [15:0] subIn, addIn;
  logic [31:0] L_subOutA, L_subOutB, memOut;
  logic [15:0] subOutA, subOutB, addOutA, addOutB;
  logic [11:0] memReadAddr, memWriteAddr;
  logic        memWriteEn, done;

  always #5 clk = ~clk;

  lsp_stability_fsm dut (
    .clk(clk), .reset(reset), .start(start), .bufAddr(bufAddr),
    .memIn(memIn), .L_subIn(L_subIn), .subIn(subIn), .addIn(addIn),
    .L_subOutA(L_subOutA), .L_subOutB(L_subOutB),
    .subOutA(subOutA), .subOutB(subOutB),
    .addOutA(addOutA), .addOutB(addOutB),
    .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
    .memOut(memOut), .memWriteEn(memWriteEn), .done(done)
  );

  // Saturating operator units.
  function automatic logic [31:0] sat_lsub(input logic [31:0] x, input logic [31:0] y);
    longint d;
    d = longint'($signed(x)) - longint'($signed(y));
    if (d > 64'sh7FFFFFFF) d = 64'sh7FFFFFFF;
    else if (d < -64'sh80000000) d = -64'sh80000000;
    return d[31:0];
  endfunction

  function automatic logic [15:0] sat16(input int d);
    int r;
    r = d;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  assign L_subIn = sat_lsub(L_subOutA, L_subOutB);
  assign subIn   = sat16(int'($signed(subOutA)) - int'($signed(subOutB)));
  assign addIn   = sat16(int'($signed(addOutA)) + int'($signed(addOutB)));

  // Scratch memory, bench-side loading and write monitoring.
  logic [15:0] mem [16];
  logic [15:0] load_buf [16];
  logic        load_req = 1'b0;
  int          wr_cnt = 0, done_cnt = 0, bad_wr = 0;

  always @(posedge clk) begin
    memIn <= {{16{mem[memReadAddr[3:0]][15]}}, mem[memReadAddr[3:0]]};
    if (load_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= load_buf[i];
    end else if (memWriteEn) begin
      mem[memWriteAddr[3:0]] <= memOut[15:0];
      wr_cnt <= wr_cnt + 1;
      if (memWriteAddr[11:4] != bufAddr[11:4] || memOut[31:16] != {16{memOut[15]}})
        bad_wr <= bad_wr + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int          cur [10];
  logic [15:0] exp_buf_q [$];
  int          exp_lat_q [$];
  int          exp_wr_q  [$];

  // Reference Lsp_stability on the current buffer contents.
  task automatic model_push();
    int v [10];
    int s, w, t;
    s = 0; w = 0;
    for (int i = 0; i < 10; i++) v[i] = cur[i];
    for (int i = 0; i < 9; i++) begin
      if (v[i+1] < v[i]) begin
        t = v[i]; v[i] = v[i+1]; v[i+1] = t;
        s++; w += 2;
      end
    end
    if (v[0] < 40) begin v[0] = 40; w++; end
    for (int i = 0; i < 9; i++) begin
      if (v[i+1] - v[i] < 321) begin
        v[i+1] = (v[i] + 321 > 32767) ? 32767 : v[i] + 321;
        w++;
      end
    end
    if (v[9] > 25681) begin v[9] = 25681; w++; end
    for (int i = 0; i < 10; i++) exp_buf_q.push_back(16'(v[i]));
    exp_lat_q.push_back(40 + s);
    exp_wr_q.push_back(w);
  endtask

  task automatic load_mem();
    for (int i = 0; i < 16; i++) load_buf[i] = (i < 10) ? 16'(cur[i]) : 16'd0;
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic run_case(input string name, input bit hold_start);
    int cyc, wb, db, bb, lat, elat, ewr;
    bit got;
    logic [15:0] ev;
    model_push();
    @(negedge clk);
    start = 1'b1;
    wb = wr_cnt; db = done_cnt; bb = bad_wr;
    cyc = 0; got = 1'b0; lat = -1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = hold_start && (cyc < 4);
      if (done) begin got = 1'b1; lat = cyc; end
    end
    start = 1'b0;
    check({name, " done_seen"}, int'(got), 1);
    @(negedge clk);
    check({name, " done_single_cycle"}, int'(done), 0);
    check({name, " done_pulses"}, done_cnt - db, 1);
    elat = exp_lat_q.pop_front();
    ewr  = exp_wr_q.pop_front();
    check({name, " latency"}, lat, elat);
    check({name, " writes"}, wr_cnt - wb, ewr);
    check({name, " write_addr_data"}, bad_wr - bb, 0);
    for (int i = 0; i < 10; i++) begin
      ev = exp_buf_q.pop_front();
      check($sformatf("%s buf[%0d]", name, i), int'($signed(mem[i])), int'($signed(ev)));
    end
  endtask

  initial begin
    int wb, db;
    reset = 1'b1; start = 1'b0; bufAddr = 12'h5A7;
    repeat (3) @(negedge clk);
    check("reset done", int'(done), 0);
    check("reset wen", int'(memWriteEn), 0);
    check("reset raddr", int'(memReadAddr), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) cur[i] = 1000 + 2000 * i;
    load_mem(); run_case("sorted", 1'b0);

    cur[0] = 5000; cur[1] = 4000;
    for (int i = 2; i < 10; i++) cur[i] = 7000 + 2000 * (i - 2);
    bufAddr = 12'hC30;
    load_mem(); run_case("one_swap", 1'b1);
    check("one_swap buf0 const", int'($signed(mem[0])), 4000);

    cur[0] = 10;
    for (int i = 1; i < 10; i++) cur[i] = 1000 * i;
    load_mem(); run_case("low_limit", 1'b0);

    for (int i = 0; i < 10; i++) cur[i] = 100 * (i + 1);
    load_mem(); run_case("gap_fix", 1'b0);
    check("gap_fix buf9 const", int'($signed(mem[9])), 2989);

    for (int i = 0; i < 9; i++) cur[i] = 1000 * (i + 1);
    cur[9] = 30000;
    load_mem(); run_case("high_limit", 1'b0);

    cur[9] = 25681;
    load_mem(); run_case("high_exact", 1'b0);

    for (int i = 0; i < 10; i++) cur[i] = 30000 + 100 * i;
    load_mem(); run_case("saturate", 1'b0);

    for (int i = 0; i < 10; i++) cur[i] = 10000 - 1000 * i;
    load_mem(); run_case("descending", 1'b0);

    cur[0] = 500;
    for (int i = 1; i < 10; i++) cur[i] = 500 + 321 * i;
    load_mem(); run_case("gap_exact", 1'b0);

    for (int r = 0; r < 4; r++) begin
      bufAddr = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 10; i++) cur[i] = int'($signed(16'($urandom_range(0, 65535))));
      load_mem(); run_case($sformatf("random%0d", r), 1'b0);
    end

    // Reset during pass 2 while a write is being driven.
    bufAddr = 12'h7F0;
    for (int i = 0; i < 10; i++) cur[i] = 100 * (i + 1);
    load_mem();
    @(negedge clk); start = 1'b1;
    repeat (24) begin @(negedge clk); start = 1'b0; end
    reset = 1'b1;
    #1;
    check("midreset wen", int'(memWriteEn), 0);
    check("midreset raddr", int'(memReadAddr), 0);
    @(negedge clk);
    reset = 1'b0;
    wb = wr_cnt; db = done_cnt;
    repeat (60) @(negedge clk);
    check("midreset no_writes", wr_cnt - wb, 0);
    check("midreset no_done", done_cnt - db, 0);
    for (int i = 0; i < 10; i++) cur[i] = int'($signed(mem[i]));
    run_case("rerun", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
